// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, segment table and frame type for the seven-segment scanner
package seg7_pkg;
    localparam int NUM_DIGITS = 4;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [3:0] AN_OFF = 4'b1111;
    // active-low {g,f,e,d,c,b,a}, entry 15 first
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    typedef struct packed {
        logic [15:0] val;
        logic        neg;
        logic        blk;
    } frame_t;

    function automatic logic [3:0] an_for(input logic [1:0] digit);
        return ~(4'b0001 << digit);
    endfunction
endpackage

// File: rtl/hex_to_7seg.sv
// hex_to_7seg: combinational hex nibble to active-low seven-segment code
module hex_to_7seg
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    assign seg = SEG_TABLE[hex];
endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: 4-digit multiplexed display driver advanced by a synchronized scan strobe
module seven_seg_scanner
    import seg7_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scan_clk,
    input  logic [15:0] value,
    input  logic        negative,
    input  logic        blank,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);
    logic [SYNC_STAGES-1:0] sync;
    logic prev, tick;
    logic [1:0] digit, digit_nxt;
    frame_t shadow, shadow_nxt;
    logic [3:0] nibble, an_nxt;
    logic [6:0] hex_seg, seg_nxt;
    logic z1, z2, z3, dark, off;

    assign dp = 1'b1;

    hex_to_7seg u_dec (.hex(nibble), .seg(hex_seg));

    // everything below looks at the post-tick digit and frame so the wrap tick shows fresh data
    always_comb begin
        digit_nxt = digit + 2'd1;
        shadow_nxt = (digit == 2'(NUM_DIGITS - 1)) ? frame_t'{val: value, neg: negative, blk: blank} : shadow;
        nibble = shadow_nxt.val[{digit_nxt, 2'b00} +: 4];
        z3 = shadow_nxt.val[15:12] == 4'h0;
        z2 = (shadow_nxt.val[11:8] == 4'h0) && (shadow_nxt.neg || z3);
        z1 = (shadow_nxt.val[7:4] == 4'h0) && z2;
        dark = BLANK_LEADING && (digit_nxt == 2'd1 ? z1 :
                                 digit_nxt == 2'd2 ? z2 :
                                 digit_nxt == 2'd3 ? (z3 && !shadow_nxt.neg) : 1'b0);
        off = shadow_nxt.blk || dark;
        an_nxt = off ? AN_OFF : an_for(digit_nxt);
        seg_nxt = off ? SEG_BLANK : (shadow_nxt.neg && digit_nxt == 2'd3) ? SEG_MINUS : hex_seg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= '0;
            prev   <= 1'b0;
            tick   <= 1'b0;
            digit  <= 2'd3;
            shadow <= '0;
            an     <= AN_OFF;
            seg    <= SEG_BLANK;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], scan_clk};
            prev <= sync[SYNC_STAGES-1];
            tick <= sync[SYNC_STAGES-1] & ~prev;
            if (tick) begin
                digit  <= digit_nxt;
                shadow <= shadow_nxt;
                an     <= an_nxt;
                seg    <= seg_nxt;
            end
        end
    end
endmodule
